// File: rtl/des_key_schedule.sv
// DES key-schedule controller: PC-1 on start, then one PC-2 subkey per handshake,
// rotating the C/D halves left (encrypt) or right (decrypt) between rounds.
module des_key_schedule (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        decrypt,
    input  logic [64:1] key_in,
    output logic        ready,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [48:1] subkey,
    output logic [5:1]  round_idx,
    output logic        done
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_EMIT = 1'b1;

    // Tables hold DES bit numbers (1 = MSB); entry 0 is output bit 1.
    localparam logic [0:55][5:0] PC1_TAB = {
        6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,  6'd1,
        6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18, 6'd10, 6'd2,
        6'd59, 6'd51, 6'd43, 6'd35, 6'd27, 6'd19, 6'd11, 6'd3,
        6'd60, 6'd52, 6'd44, 6'd36, 6'd63, 6'd55, 6'd47, 6'd39,
        6'd31, 6'd23, 6'd15, 6'd7,  6'd62, 6'd54, 6'd46, 6'd38,
        6'd30, 6'd22, 6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37,
        6'd29, 6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
    };

    localparam logic [0:47][5:0] PC2_TAB = {
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28,
        6'd15, 6'd6,  6'd21, 6'd10, 6'd23, 6'd19, 6'd12, 6'd4,
        6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40,
        6'd51, 6'd45, 6'd33, 6'd48, 6'd44, 6'd49, 6'd39, 6'd56,
        6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    logic        state;
    logic        mode;
    logic [4:0]  n;
    logic [27:0] c;
    logic [27:0] d;
    logic        done_r;
    logic [55:0] cd0;
    logic        two_enc;
    logic        two_dec;
    logic        unused_parity;

    function automatic logic [55:0] pc1(input logic [64:1] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[55 - i] = k[65 - int'(PC1_TAB[i])];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int j = 0; j < 48; j++) begin
            r[47 - j] = cd[56 - int'(PC2_TAB[j])];
        end
        return r;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] h, input logic two);
        return two ? {h[25:0], h[27:26]} : {h[26:0], h[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] h, input logic two);
        return two ? {h[1:0], h[27:2]} : {h[0], h[27:1]};
    endfunction

    // Rounds 1, 2, 9 and 16 rotate by one position, all others by two.
    function automatic logic shift_two(input logic [4:0] r);
        return !((r == 5'd1) || (r == 5'd2) || (r == 5'd9) || (r == 5'd16));
    endfunction

    assign cd0     = pc1(key_in);
    assign two_enc = shift_two(n + 5'd1);
    assign two_dec = shift_two(5'd17 - n);

    assign unused_parity = ^{key_in[57], key_in[49], key_in[41], key_in[33],
                             key_in[25], key_in[17], key_in[9],  key_in[1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            mode   <= 1'b0;
            n      <= 5'd0;
            c      <= '0;
            d      <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (state == ST_IDLE) begin
                if (start) begin
                    state <= ST_EMIT;
                    mode  <= decrypt;
                    n     <= 5'd1;
                    // C0/D0 already equals C16/D16, so decryption starts unrotated.
                    if (decrypt) begin
                        c <= cd0[55:28];
                        d <= cd0[27:0];
                    end else begin
                        c <= rotl(cd0[55:28], 1'b0);
                        d <= rotl(cd0[27:0], 1'b0);
                    end
                end
            end else if (subkey_ready) begin
                if (n == 5'd16) begin
                    state  <= ST_IDLE;
                    done_r <= 1'b1;
                end else begin
                    n <= n + 5'd1;
                    if (mode) begin
                        c <= rotr(c, two_dec);
                        d <= rotr(d, two_dec);
                    end else begin
                        c <= rotl(c, two_enc);
                        d <= rotl(d, two_enc);
                    end
                end
            end
        end
    end

    assign ready        = (state == ST_IDLE);
    assign subkey_valid = (state == ST_EMIT);
    assign subkey       = subkey_valid ? pc2({c, d}) : 48'd0;
    assign round_idx    = subkey_valid ? (mode ? (5'd17 - n) : n) : 5'd0;
    assign done         = done_r;

endmodule

// File: tb/tb_des_key_schedule.sv
// Randomized bench for des_key_schedule against a table-driven DES key-schedule model.
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        decrypt;
    logic [63:0] key_in;
    logic        ready;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [47:0] subkey;
    logic [4:0]  round_idx;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [47:0] got [1:16];
    logic [47:0] enc_ref [1:16];

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;

    int pc1_t [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,
                       59,51,43,35,27,19,11,3,60,52,44,36,63,55,47,39,
                       31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,
                       29,21,13,5,28,20,12,4};
    int pc2_t [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,
                       26,8,16,7,27,20,13,2,41,52,31,37,47,55,30,40,
                       51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};

    des_key_schedule dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .decrypt      (decrypt),
        .key_in       (key_in),
        .ready        (ready),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .subkey       (subkey),
        .round_idx    (round_idx),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Subkey r from the cumulative left rotation of C0/D0 (sum of shifts 1..r).
    function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int r);
        int kb [1:64];
        int c0 [1:28];
        int d0 [1:28];
        int cd [1:56];
        int total;
        logic [47:0] res;
        for (int i = 1; i <= 64; i++) kb[i] = int'(key[64 - i]);
        for (int j = 1; j <= 28; j++) begin
            c0[j] = kb[pc1_t[j - 1]];
            d0[j] = kb[pc1_t[j + 27]];
        end
        total = 0;
        for (int k = 1; k <= r; k++) total += (k == 1 || k == 2 || k == 9 || k == 16) ? 1 : 2;
        for (int j = 1; j <= 28; j++) begin
            cd[j]      = c0[((j - 1 + total) % 28) + 1];
            cd[j + 28] = d0[((j - 1 + total) % 28) + 1];
        end
        res = '0;
        for (int j = 1; j <= 48; j++) res[48 - j] = cd[pc2_t[j - 1]][0];
        return res;
    endfunction

    task automatic check_idle_outputs(input string tag, input logic exp_done);
        check({tag, "_ready"}, ready, 1);
        check({tag, "_valid"}, subkey_valid, 0);
        check({tag, "_subkey"}, subkey, 0);
        check({tag, "_round"}, round_idx, 0);
        check({tag, "_done"}, done, exp_done);
    endtask

    // bp: 0 = always ready, 1 = random, 2 = 5-cycle stall at round 3 then random.
    task automatic run_schedule(input logic [63:0] key, input logic dec, input int bp,
                                input int inject_r, input int abort_r, output int cycles);
        int e;
        int r;
        int stall;
        bit injected;
        start        = 1'b1;
        key_in       = key;
        decrypt      = dec;
        subkey_ready = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        key_in   = {$urandom, $urandom};
        cycles   = 1;
        e        = 0;
        stall    = 0;
        injected = 0;
        while (e < 16) begin
            if (cycles > 400) begin
                check("timeout", 64'(e), 64'd16);
                return;
            end
            r = dec ? 16 - e : e + 1;
            check("valid", subkey_valid, 1);
            check("ready_busy", ready, 0);
            check("done_busy", done, 0);
            check("round_idx", round_idx, 64'(r));
            check("subkey", subkey, ref_subkey(key, r));
            got[r] = subkey;
            if (bp == 0) subkey_ready = 1'b1;
            else if (bp == 2 && r == 3 && stall < 5) begin
                subkey_ready = 1'b0;
                stall++;
            end else subkey_ready = ($urandom_range(0, 99) < 65);
            if (r == inject_r && !injected) begin
                start    = 1'b1;
                key_in   = ~key;
                decrypt  = ~dec;
                injected = 1;
            end else start = 1'b0;
            if (r == abort_r && subkey_ready) begin
                rst = 1'b1;
                @(negedge clk);
                check_idle_outputs("abort", 1'b0);
                rst = 1'b0;
                return;
            end
            if (subkey_ready) e++;
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        check_idle_outputs("end", 1'b1);
    endtask

    initial begin
        int cyc;
        logic [63:0] k;
        logic dm;
        rst          = 1'b1;
        start        = 1'b0;
        decrypt      = 1'b0;
        key_in       = '0;
        subkey_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_idle_outputs("reset", 1'b0);
        rst = 1'b0;
        @(negedge clk);

        run_schedule(KEY_A, 1'b0, 0, 0, 0, cyc);
        check("enc_latency", 64'(cyc), 64'd17);
        check("k1_vector", got[1], 48'h1B02EFFC7072);
        check("k2_vector", got[2], 48'h79AED9DBC9E5);
        check("k16_vector", got[16], 48'hCB3D8B0E17F5);
        for (int i = 1; i <= 16; i++) enc_ref[i] = got[i];
        @(negedge clk);
        check("done_width", done, 0);

        run_schedule(KEY_A, 1'b1, 0, 0, 0, cyc);
        check("dec_latency", 64'(cyc), 64'd17);
        for (int i = 1; i <= 16; i++) check("dec_vs_enc", got[i], enc_ref[i]);
        @(negedge clk);

        run_schedule(KEY_A, 1'b0, 2, 0, 0, cyc);
        for (int i = 1; i <= 16; i++) check("stall_vs_enc", got[i], enc_ref[i]);
        @(negedge clk);

        run_schedule(64'h0, 1'b0, 0, 0, 0, cyc);
        for (int i = 1; i <= 16; i++) check("zero_key", got[i], 48'h0);
        run_schedule(64'hFFFFFFFFFFFFFFFF, 1'b1, 1, 0, 0, cyc);
        for (int i = 1; i <= 16; i++) check("ones_key", got[i], 48'hFFFFFFFFFFFF);
        run_schedule(64'h0101010101010101, 1'b0, 1, 0, 0, cyc);
        for (int i = 1; i <= 16; i++) check("parity_key", got[i], 48'h0);
        @(negedge clk);

        run_schedule(KEY_A, 1'b0, 0, 7, 0, cyc);
        for (int i = 1; i <= 16; i++) check("busy_start", got[i], enc_ref[i]);
        @(negedge clk);

        run_schedule(KEY_A, 1'b0, 0, 0, 9, cyc);
        @(negedge clk);
        check_idle_outputs("post_abort", 1'b0);
        run_schedule(KEY_A, 1'b0, 1, 0, 0, cyc);
        check("after_abort_k1", got[1], 48'h1B02EFFC7072);
        @(negedge clk);

        for (int t = 0; t < 8; t++) begin
            k  = {$urandom, $urandom};
            dm = 1'($urandom_range(0, 1));
            run_schedule(k, dm, 1, 0, 0, cyc);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        @(negedge clk);
        check("final_done", done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
